alarm_sequencer: RTL and testbench

//   Master FSM of the alarm system. Sequences the arm/exit-delay/armed/entry-delay/alarm cycle.

---
 rtl/alarm_sequencer.sv | 101 ++++++++++
 tb/tb_alarm_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_sequencer.sv
// Master alarm FSM: DISARMED -> EXIT -> ARMED -> ENTRY -> ALARM, with one prescaled countdown shared by the delays.
// All outputs are registered and reflect the new state on the same edge that samples the cause.
module alarm_sequencer #(
   parameter int TICK_DIV   = 50_000_000,
   parameter int EXIT_SECS  = 10,
   parameter int ENTRY_SECS = 10,
   parameter int ALARM_SECS = 180
) (
   input  logic       clock50,
   input  logic       Mr,
   input  logic       arm_req,
   input  logic       disarm_req,
   input  logic       sensor,
   input  logic       tamper,
   output logic [2:0] state,
   output logic       armed_led,
   output logic       warn_beep,
   output logic       siren,
   output logic [7:0] secs_left
);

   typedef enum logic [2:0] {
      S_DISARMED = 3'd0,
      S_EXIT     = 3'd1,
      S_ARMED    = 3'd2,
      S_ENTRY    = 3'd3,
      S_ALARM    = 3'd4
   } state_t;

   localparam int TW = $clog2(TICK_DIV);

   state_t        state_q, state_d;
   logic [7:0]    secs_q, secs_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          armed_led_q, warn_beep_q, siren_q;
   logic          timed, tick, expire, reload;

   always_comb begin
      timed  = (state_q == S_EXIT) || (state_q == S_ENTRY) || (state_q == S_ALARM);
      tick   = timed && (tick_cnt_q == TW'(TICK_DIV - 1));
      expire = tick && (secs_q <= 8'd1);

      state_d = state_q;
      if (tamper) begin
         state_d = S_ALARM;
      end else if (disarm_req && (state_q != S_DISARMED)) begin
         state_d = S_DISARMED;
      end else begin
         case (state_q)
            S_DISARMED: if (arm_req) state_d = S_EXIT;
            S_EXIT:     if (expire)  state_d = S_ARMED;
            S_ARMED:    if (sensor)  state_d = S_ENTRY;
            S_ENTRY:    if (expire)  state_d = S_ALARM;
            S_ALARM:    if (expire)  state_d = S_ARMED;
            default:    state_d = S_DISARMED;
         endcase
      end

      // Any state entry (and tamper while already in ALARM) restarts the countdown from scratch.
      reload     = tamper || (state_d != state_q);
      secs_d     = secs_q;
      tick_cnt_d = '0;
      if (reload) begin
         case (state_d)
            S_EXIT:  secs_d = 8'(EXIT_SECS);
            S_ENTRY: secs_d = 8'(ENTRY_SECS);
            S_ALARM: secs_d = 8'(ALARM_SECS);
            default: secs_d = 8'd0;
         endcase
      end else if (tick) begin
         secs_d = secs_q - 8'd1;
      end else if (timed) begin
         tick_cnt_d = tick_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock50 or negedge Mr) begin
      if (!Mr) begin
         state_q     <= S_DISARMED;
         secs_q      <= 8'd0;
         tick_cnt_q  <= '0;
         armed_led_q <= 1'b0;
         warn_beep_q <= 1'b0;
         siren_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         secs_q      <= secs_d;
         tick_cnt_q  <= tick_cnt_d;
         armed_led_q <= (state_d != S_DISARMED);
         warn_beep_q <= (state_d == S_EXIT) || (state_d == S_ENTRY);
         siren_q     <= (state_d == S_ALARM);
      end
   end

   assign state     = state_q;
   assign secs_left = secs_q;
   assign armed_led = armed_led_q;
   assign warn_beep = warn_beep_q;
   assign siren     = siren_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: directed scenarios plus a randomized run against a cycle-count reference model.
module tb_alarm_sequencer;

   localparam int TD = 4;
   localparam int EX = 3;
   localparam int EN = 2;
   localparam int AL = 5;

   logic       clock50 = 1'b0;
   logic       Mr = 1'b0;
   logic       arm_req = 1'b0;
   logic       disarm_req = 1'b0;
   logic       sensor = 1'b0;
   logic       tamper = 1'b0;
   logic [2:0] state;
   logic       armed_led, warn_beep, siren;
   logic [7:0] secs_left;

   int checks = 0;
   int failures = 0;

   // Reference model: phase, its length in ticks, and cycles elapsed since entering it.
   int m_state;
   int m_n;
   int m_el;

   alarm_sequencer #(
      .TICK_DIV(TD), .EXIT_SECS(EX), .ENTRY_SECS(EN), .ALARM_SECS(AL)
   ) dut (
      .clock50(clock50), .Mr(Mr), .arm_req(arm_req), .disarm_req(disarm_req),
      .sensor(sensor), .tamper(tamper), .state(state), .armed_led(armed_led),
      .warn_beep(warn_beep), .siren(siren), .secs_left(secs_left)
   );

   always #5 clock50 = ~clock50;

   task automatic wait_n(input int n);
      repeat (n) @(negedge clock50);
   endtask

   task automatic model_enter(input int s);
      m_state = s;
      m_el    = 0;
      m_n     = (s == 1) ? EX : (s == 3) ? EN : (s == 4) ? AL : 0;
   endtask

   task automatic model_edge(input bit arm, input bit dis, input bit sen, input bit tam);
      bit expired;
      expired = (m_n != 0) && (m_el + 1 == m_n * TD);
      if (tam) model_enter(4);
      else if (dis && m_state != 0) model_enter(0);
      else begin
         case (m_state)
            0: if (arm) model_enter(1);
            1: if (expired) model_enter(2); else m_el++;
            2: if (sen) model_enter(3);
            3: if (expired) model_enter(4); else m_el++;
            default: if (expired) model_enter(2); else m_el++;
         endcase
      end
   endtask

   task automatic test_reset();
      Mr = 1'b0;
      #2;
      checks++;
      if (state !== 3'd0 || secs_left !== 8'd0 || armed_led !== 1'b0 || warn_beep !== 1'b0 || siren !== 1'b0) begin
         failures++;
         $display("FAIL reset: state=%0d secs=%0d led=%b beep=%b siren=%b expected all 0",
                  state, secs_left, armed_led, warn_beep, siren);
      end
      @(negedge clock50);
      Mr = 1'b1;
      wait_n(2);
      checks++;
      if (state !== 3'd0) begin
         failures++;
         $display("FAIL reset_idle: state=%0d expected 0", state);
      end
   endtask

   task automatic test_arm_exit();
      arm_req = 1'b1;
      @(negedge clock50);
      arm_req = 1'b0;
      checks++;
      if (state !== 3'd1 || secs_left !== 8'd3 || warn_beep !== 1'b1 || armed_led !== 1'b1) begin
         failures++;
         $display("FAIL exit_entry: state=%0d secs=%0d beep=%b led=%b expected 1/3/1/1",
                  state, secs_left, warn_beep, armed_led);
      end
      wait_n(4);
      checks++;
      if (state !== 3'd1 || secs_left !== 8'd2) begin
         failures++;
         $display("FAIL exit_4cyc: state=%0d secs=%0d expected 1/2", state, secs_left);
      end
      wait_n(4);
      checks++;
      if (state !== 3'd1 || secs_left !== 8'd1) begin
         failures++;
         $display("FAIL exit_8cyc: state=%0d secs=%0d expected 1/1", state, secs_left);
      end
      wait_n(4);
      checks++;
      if (state !== 3'd2 || secs_left !== 8'd0 || warn_beep !== 1'b0 || armed_led !== 1'b1) begin
         failures++;
         $display("FAIL exit_expiry: state=%0d secs=%0d beep=%b led=%b expected 2/0/0/1",
                  state, secs_left, warn_beep, armed_led);
      end
   endtask

   task automatic test_entry_alarm();
      sensor = 1'b1;
      @(negedge clock50);
      sensor = 1'b0;
      checks++;
      if (state !== 3'd3 || warn_beep !== 1'b1 || secs_left !== 8'd2) begin
         failures++;
         $display("FAIL entry: state=%0d beep=%b secs=%0d expected 3/1/2", state, warn_beep, secs_left);
      end
      wait_n(8);
      checks++;
      if (state !== 3'd4 || siren !== 1'b1 || secs_left !== 8'd5 || warn_beep !== 1'b0) begin
         failures++;
         $display("FAIL alarm: state=%0d siren=%b secs=%0d beep=%b expected 4/1/5/0",
                  state, siren, secs_left, warn_beep);
      end
      wait_n(19);
      checks++;
      if (state !== 3'd4 || secs_left !== 8'd1) begin
         failures++;
         $display("FAIL alarm_last: state=%0d secs=%0d expected 4/1", state, secs_left);
      end
      wait_n(1);
      checks++;
      if (state !== 3'd2 || siren !== 1'b0 || secs_left !== 8'd0) begin
         failures++;
         $display("FAIL rearm: state=%0d siren=%b secs=%0d expected 2/0/0", state, siren, secs_left);
      end
   endtask

   task automatic test_disarm_beats_expiry();
      bit siren_seen;
      siren_seen = 1'b0;
      sensor = 1'b1;
      @(negedge clock50);
      sensor = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clock50);
         if (siren) siren_seen = 1'b1;
      end
      checks++;
      if (state !== 3'd3 || secs_left !== 8'd1) begin
         failures++;
         $display("FAIL entry_last: state=%0d secs=%0d expected 3/1", state, secs_left);
      end
      disarm_req = 1'b1;
      @(negedge clock50);
      disarm_req = 1'b0;
      if (siren) siren_seen = 1'b1;
      checks++;
      if (state !== 3'd0 || secs_left !== 8'd0 || siren_seen !== 1'b0) begin
         failures++;
         $display("FAIL disarm_vs_expiry: state=%0d secs=%0d siren_seen=%b expected 0/0/0",
                  state, secs_left, siren_seen);
      end
   endtask

   task automatic test_tamper();
      tamper = 1'b1;
      @(negedge clock50);
      checks++;
      if (state !== 3'd4 || siren !== 1'b1 || secs_left !== 8'd5) begin
         failures++;
         $display("FAIL tamper: state=%0d siren=%b secs=%0d expected 4/1/5", state, siren, secs_left);
      end
      disarm_req = 1'b1;
      @(negedge clock50);
      disarm_req = 1'b0;
      checks++;
      if (state !== 3'd4 || secs_left !== 8'd5) begin
         failures++;
         $display("FAIL tamper_vs_disarm: state=%0d secs=%0d expected 4/5", state, secs_left);
      end
      tamper = 1'b0;
      @(negedge clock50);
      disarm_req = 1'b1;
      @(negedge clock50);
      disarm_req = 1'b0;
      checks++;
      if (state !== 3'd0 || siren !== 1'b0 || armed_led !== 1'b0) begin
         failures++;
         $display("FAIL disarm_after_tamper: state=%0d siren=%b led=%b expected 0/0/0",
                  state, siren, armed_led);
      end
   endtask

   task automatic test_ignored_and_sensor_in_exit();
      arm_req = 1'b1;
      @(negedge clock50);
      arm_req = 1'b0;
      wait_n(12);
      arm_req = 1'b1;
      @(negedge clock50);
      arm_req = 1'b0;
      checks++;
      if (state !== 3'd2 || secs_left !== 8'd0) begin
         failures++;
         $display("FAIL arm_in_armed: state=%0d secs=%0d expected 2/0", state, secs_left);
      end
      disarm_req = 1'b1;
      @(negedge clock50);
      disarm_req = 1'b0;
      disarm_req = 1'b1;
      @(negedge clock50);
      disarm_req = 1'b0;
      checks++;
      if (state !== 3'd0) begin
         failures++;
         $display("FAIL disarm_in_disarmed: state=%0d expected 0", state);
      end
      sensor  = 1'b1;
      arm_req = 1'b1;
      @(negedge clock50);
      arm_req = 1'b0;
      wait_n(11);
      checks++;
      if (state !== 3'd1 || secs_left !== 8'd1) begin
         failures++;
         $display("FAIL exit_sensor_ignored: state=%0d secs=%0d expected 1/1", state, secs_left);
      end
      wait_n(1);
      checks++;
      if (state !== 3'd2) begin
         failures++;
         $display("FAIL exit_to_armed: state=%0d expected 2", state);
      end
      wait_n(1);
      checks++;
      if (state !== 3'd3 || secs_left !== 8'd2) begin
         failures++;
         $display("FAIL armed_to_entry: state=%0d secs=%0d expected 3/2", state, secs_left);
      end
      sensor = 1'b0;
      disarm_req = 1'b1;
      @(negedge clock50);
      disarm_req = 1'b0;
   endtask

   task automatic test_async_reset_mid_alarm();
      tamper = 1'b1;
      @(negedge clock50);
      tamper = 1'b0;
      wait_n(2);
      #3;
      Mr = 1'b0;
      #1;
      checks++;
      if (state !== 3'd0 || siren !== 1'b0 || armed_led !== 1'b0 || secs_left !== 8'd0) begin
         failures++;
         $display("FAIL async_reset: state=%0d siren=%b led=%b secs=%0d expected all 0",
                  state, siren, armed_led, secs_left);
      end
      @(negedge clock50);
      Mr = 1'b1;
      wait_n(TD * AL + 2);
      checks++;
      if (state !== 3'd0 || secs_left !== 8'd0) begin
         failures++;
         $display("FAIL reset_abandons: state=%0d secs=%0d expected 0/0", state, secs_left);
      end
   endtask

   task automatic test_random();
      bit a, d, s, t;
      int exp_secs;
      @(negedge clock50);
      Mr = 1'b0;
      #2;
      Mr = 1'b1;
      @(negedge clock50);
      model_enter(0);
      s = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         exp_secs = (m_n == 0) ? 0 : m_n - m_el / TD;
         checks++;
         if (state !== m_state[2:0] || secs_left !== exp_secs[7:0] ||
             armed_led !== (m_state != 0) || warn_beep !== (m_state == 1 || m_state == 3) ||
             siren !== (m_state == 4)) begin
            failures++;
            $display("FAIL random cyc %0d: state=%0d secs=%0d led=%b beep=%b siren=%b expected state=%0d secs=%0d",
                     i, state, secs_left, armed_led, warn_beep, siren, m_state, exp_secs);
         end
         a = ($urandom_range(0, 5) == 0);
         d = ($urandom_range(0, 39) == 0);
         t = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 9) == 0) s = ~s;
         arm_req = a; disarm_req = d; sensor = s; tamper = t;
         @(negedge clock50);
         model_edge(a, d, s, t);
      end
      arm_req = 1'b0; disarm_req = 1'b0; sensor = 1'b0; tamper = 1'b0;
   endtask

   initial begin
      test_reset();
      test_arm_exit();
      test_entry_alarm();
      test_disarm_beats_expiry();
      test_tamper();
      test_ignored_and_sensor_in_exit();
      test_async_reset_mid_alarm();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
